nibble_serial_alu_ctrl: RTL and testbench

Sequencing controller that wraps the team's 4-bit parallel adder slice to perform multi-nibble (default 16-bit) add/subtract operations, one nibble per clock, least-significant nibble first. It latches wide operands on a start handshake and drives the slice's `a`/`b`/`s0`/`s1`/`cin` inputs each cycle. It consumes the slice's `s`/`cout`, chains the carry through a register, and presents the assembled result with done/zero flags. In the security datapath it feeds PIN comparison (subtract-and-test-zero) and attempt/timer arithmetic.

---
 rtl/nibble_serial_alu_ctrl.sv | 99 +++++++++
 tb/tb_nibble_serial_alu_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-nibble add/subtract sequencer around a 4-bit parallel adder slice.
// One nibble per clock, LSB first, carry chained through a register.
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 cin_in,
  input  logic [4*NIBBLES-1:0] opa,
  input  logic [4*NIBBLES-1:0] opb,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_s0,
  output logic                 add_s1,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q;
  logic                     carry_q;
  logic                     cout_q;
  logic                     cin_q;
  logic [1:0]               op_q;
  logic [NIBBLES-1:0][3:0]  a_q, b_q, res_q;
  logic                     run, accept;

  assign run    = (state_q == RUN);
  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cin_q   <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= opa;
        b_q     <= opb;
        op_q    <= op;
        cin_q   <= cin_in;
        res_q   <= '0;
        idx_q   <= '0;
        carry_q <= 1'b0;
      end else if (run) begin
        res_q[idx_q] <= add_s;
        carry_q      <= add_cout;
        if (idx_q == LAST) begin
          cout_q <= add_cout;
          idx_q  <= '0;
        end else begin
          idx_q  <= idx_q + 1'b1;
        end
      end
    end
  end

  // Slice inputs are forced to 0 outside RUN; carry comes only from the register.
  assign add_a   = run ? a_q[idx_q] : 4'h0;
  assign add_b   = run ? b_q[idx_q] : 4'h0;
  assign add_s0  = run & op_q[0];
  assign add_s1  = run & op_q[1];
  assign add_cin = run & ((idx_q == '0) ? cin_q : carry_q);

  assign busy   = run;
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign zero   = ~|res_q;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench: directed and random ops checked against a plain-arithmetic reference.
module tb_nibble_serial_alu_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         cin_in = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_s0, add_s1, add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin_in(cin_in),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .add_a(add_a), .add_b(add_b),
    .add_s0(add_s0), .add_s1(add_s1), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  // Adder slice: s0 selects inverted b, giving a+b+cin or a+~b+cin.
  logic [4:0] slice_sum;
  always_comb begin
    slice_sum = {1'b0, add_a} + {1'b0, (add_s0 ? ~add_b : add_b)} + {4'b0, add_cin};
  end
  assign add_s    = slice_sum[3:0];
  assign add_cout = slice_sum[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Returns at the negedge where done should be high.
  task automatic op_walk(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, input logic c, input bit pulse);
    logic [W-1:0]    beff;
    logic [W:0]      full;
    longint unsigned m, car;
    beff = o[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c};
    opa = a; opb = b; op = o; cin_in = c; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 1) begin
        opa = ~a; opb = ~b; op = ~o; cin_in = ~c;
        if (pulse) start = 1'b1;
      end
      if (i == 2) start = 1'b0;
      m   = (64'd1 << (4 * i)) - 64'd1;
      car = ((longint'(a) & m) + (longint'(beff) & m) + longint'(c)) >> (4 * i);
      chk($sformatf("busy[%0d]", i), busy, 1'b1);
      chk($sformatf("done_run[%0d]", i), done, 1'b0);
      chk($sformatf("add_a[%0d]", i), add_a, a[4*i +: 4]);
      chk($sformatf("add_b[%0d]", i), add_b, b[4*i +: 4]);
      chk($sformatf("add_cin[%0d]", i), add_cin, car[0]);
      chk($sformatf("add_s0[%0d]", i), add_s0, o[0]);
      chk($sformatf("add_s1[%0d]", i), add_s1, o[1]);
    end
    @(negedge clk);
    chk("done", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("result", result, full[W-1:0]);
    chk("cout", cout, full[W]);
    chk("zero", zero, (full[W-1:0] == '0));
    chk("add_a_idle", add_a, 4'h0);
  endtask

  task automatic settle_idle(input logic [W-1:0] exp_res);
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("held_result", result, exp_res);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    logic         rc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_add", {add_a, add_b, add_s0, add_s1, add_cin}, '0);
    repeat (2) @(negedge clk);
    chk("idle_no_done", done, 1'b0);

    op_walk(16'h1234, 16'h0FCD, 2'b00, 1'b0, 0);
    chk("dir_add", result, 16'h2201);
    settle_idle(16'h2201);

    op_walk(16'hFFFF, 16'h0001, 2'b00, 1'b0, 0);
    chk("dir_ripple_cout", cout, 1'b1);
    settle_idle(16'h0000);

    op_walk(16'h4321, 16'h4321, 2'b01, 1'b1, 0);
    chk("pin_eq_zero", zero, 1'b1);
    settle_idle(16'h0000);
    op_walk(16'h4320, 16'h4321, 2'b01, 1'b1, 0);
    chk("pin_ne", result, 16'hFFFF);
    settle_idle(16'hFFFF);

    op_walk(16'h0A0B, 16'h0102, 2'b00, 1'b1, 1);
    settle_idle(16'h0B0E);
    @(negedge clk);
    chk("not_queued", busy, 1'b0);

    op_walk(16'h8000, 16'h8000, 2'b00, 1'b0, 0);
    op_walk(16'h0005, 16'h0003, 2'b01, 1'b1, 0);
    chk("b2b_second", result, 16'h0002);
    settle_idle(16'h0002);

    // Abort with the third nibble on the slice.
    opa = 16'h5555; opb = 16'h1111; op = 2'b00; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_zero", zero, 1'b1);
    chk("abort_add", {add_a, add_b, add_s0, add_s1, add_cin}, '0);
    @(negedge clk); rst = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    chk("abort_result_after", result, '0);

    op_walk(16'h00FF, 16'h0001, 2'b00, 1'b0, 0);
    chk("post_abort", result, 16'h0100);
    settle_idle(16'h0100);

    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ro = {1'b0, 1'($urandom)};
      rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      op_walk(ra, rb, ro, rc, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) begin
        start = 1'b0;
        @(negedge clk);
        chk("rnd_done_end", done, 1'b0);
      end
    end
    start = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
